// File: rtl/zbt_pix_reader.sv
// zbt_pix_reader
//   Display-side reader for ZBT bank 1. Each line is prefetched during
//   horizontal blanking into a small credit-managed word FIFO. The FIFO is
//   then drained one 18-bit pixel per clock, aligned to hcount/vcount.
//
// Ports
//   clk           pixel clock
//   reset         synchronous, active-high
//   hcount        horizontal counter (display pipeline timing)
//   vcount        vertical counter
//   read_data     ZBT read word {pixel even [35:18], pixel odd [17:0]}
//   read_addr     ZBT read address {line[9:0], col[8:0]} (registered)
//   pixel         RGB 6/6/6 for the previous cycle's hcount/vcount
//   pixel_active  pixel belongs to an active-region position
//   underrun      sticky: an active pixel found the FIFO empty
//   sync_err      sticky: words resident or in flight at a prefetch event
module zbt_pix_reader #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned V_TOTAL    = 525,
    parameter int unsigned H_PREFETCH = 700,
    parameter int unsigned ZBT_LAT    = 2,
    parameter int unsigned DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [35:0] read_data,
    output logic [18:0] read_addr,
    output logic [17:0] pixel,
    output logic        pixel_active,
    output logic        underrun,
    output logic        sync_err
);

    localparam int unsigned WORDS = H_ACTIVE / 2;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned PL    = ZBT_LAT + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t        state, state_next;
    logic [9:0]    line, next_line, issue_line;
    logic [8:0]    col, issue_col;
    logic [PL-1:0] vpipe;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, inflight;
    logic          prefetch, next_active, flush, credit_ok;
    logic          issue, push, pop, active, empty;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < PL; i++)
            inflight = inflight + CW'(vpipe[i]);
    end

    assign prefetch    = (hcount == 11'(H_PREFETCH));
    assign next_line   = (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
    assign next_active = (next_line < 10'(V_ACTIVE));
    assign flush       = prefetch && ((count != '0) || (inflight != '0));
    assign credit_ok   = ({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
    assign active      = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign empty       = (count == '0);
    assign push        = vpipe[PL-1] && !flush;
    assign pop         = active && hcount[0] && !empty;

    // The prefetch event always issues col 0 of the new line in the same
    // cycle: any residue is flushed by that event, so a full credit pool is
    // guaranteed for that first read.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_line = line;
        issue_col  = col;
        if (prefetch) begin
            if (next_active) begin
                state_next = FETCH;
                issue      = 1'b1;
                issue_line = next_line;
                issue_col  = '0;
            end else begin
                state_next = IDLE;
            end
        end else if (state == FETCH && credit_ok) begin
            issue = 1'b1;
        end
        if (issue && issue_col == 9'(WORDS - 1))
            state_next = DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= read_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line         <= '0;
            col          <= '0;
            read_addr    <= '0;
            vpipe        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pixel        <= '0;
            pixel_active <= 1'b0;
            underrun     <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            if (issue) begin
                read_addr <= {issue_line, issue_col};
                line      <= issue_line;
                col       <= issue_col + 9'd1;
            end

            // A flush drops every in-flight return but keeps this cycle's issue.
            if (flush) vpipe <= PL'(issue);
            else       vpipe <= (vpipe << 1) | PL'(issue);

            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                sync_err <= 1'b1;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end

            pixel_active <= active;
            pixel        <= '0;
            if (active) begin
                if (empty)
                    underrun <= 1'b1;
                else
                    pixel <= hcount[0] ? mem[rd_ptr][17:0] : mem[rd_ptr][35:18];
            end
        end
    end

endmodule

// File: tb/tb_zbt_pix_reader.sv
module tb_zbt_pix_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [35:0] read_data;
    logic [18:0] read_addr;
    logic [17:0] pixel;
    logic        pixel_active;
    logic        underrun;
    logic        sync_err;

    logic [35:0] zbt_d1, zbt_d2;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_line = 0;
    bit exp_valid = 1'b0;
    int act_cnt  = 0;

    zbt_pix_reader #(
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .H_TOTAL   (800),
        .V_TOTAL   (525),
        .H_PREFETCH(700),
        .ZBT_LAT   (2),
        .DEPTH     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .read_data   (read_data),
        .read_addr   (read_addr),
        .pixel       (pixel),
        .pixel_active(pixel_active),
        .underrun    (underrun),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // ZBT model: word(addr) = {addr[17:0], ~addr[17:0]}, two cycles after read_addr.
    always @(posedge clk) begin
        zbt_d1 <= {read_addr[17:0], ~read_addr[17:0]};
        zbt_d2 <= zbt_d1;
    end
    assign read_data = zbt_d2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [17:0] pix_model(input int ln, input int h);
        logic [18:0] a;
        a = 19'(((ln % 1024) * 512) + (h / 2));
        return (h % 2 == 1) ? ~a[17:0] : a[17:0];
    endfunction

    // Drive one position, clock it, then compare the registered outputs for it.
    task automatic cyc(input int h, input int v);
        bit          act;
        logic [17:0] exp_pix;
        hcount = 11'(h);
        vcount = 10'(v);
        @(posedge clk);
        #1;
        act     = (h < 640) && (v < 480);
        exp_pix = (act && exp_valid) ? pix_model(exp_line, h) : 18'd0;
        check($sformatf("act h=%0d v=%0d", h, v), 32'(pixel_active), 32'(act));
        check($sformatf("pix h=%0d v=%0d", h, v), 32'(pixel), 32'(exp_pix));
        if (pixel_active) act_cnt++;
    endtask

    task automatic run_range(input int h0, input int h1, input int v);
        for (int h = h0; h <= h1; h++) cyc(h, v);
    endtask

    initial begin
        reset  = 1'b1;
        hcount = 11'd0;
        vcount = 10'd524;
        repeat (3) @(posedge clk);
        #1;
        check("rst read_addr", 32'(read_addr), 32'h0);
        check("rst pixel", 32'(pixel), 32'h0);
        check("rst pixel_active", 32'(pixel_active), 32'h0);
        check("rst underrun", 32'(underrun), 32'h0);
        check("rst sync_err", 32'(sync_err), 32'h0);
        reset = 1'b0;

        // vcount=524: prefetch of line 0, eight issues then credit stall.
        exp_valid = 1'b0;
        run_range(0, 699, 524);
        for (int k = 0; k < 8; k++) begin
            cyc(700 + k, 524);
            check($sformatf("issue addr k=%0d", k), 32'(read_addr), 32'(k));
        end
        run_range(708, 799, 524);
        check("stall addr", 32'(read_addr), 32'h7);

        // Line 0 streams fully.
        exp_valid = 1'b1;
        exp_line  = 0;
        act_cnt   = 0;
        run_range(0, 799, 0);
        check("line0 active count", 32'(act_cnt), 32'd640);
        check("line0 underrun", 32'(underrun), 32'h0);
        check("line0 sync_err", 32'(sync_err), 32'h0);

        // Line 1, then prefetch taken at vcount=4 so line 5 is fetched.
        exp_line = 1;
        run_range(0, 699, 1);
        run_range(700, 799, 4);

        // Line 5: last issue is col 319, then DONE holds until the event.
        exp_line = 5;
        run_range(0, 699, 5);
        check("line5 col319 addr", 32'(read_addr), 32'h00B3F);
        cyc(700, 9);
        check("line10 first addr", 32'(read_addr), 32'h01400);
        run_range(701, 799, 9);

        // Line 10 partially consumed: residue at the event sets sync_err.
        exp_line = 10;
        run_range(0, 99, 10);
        check("sync_err before", 32'(sync_err), 32'h0);
        cyc(700, 10);
        check("sync_err after residue", 32'(sync_err), 32'h1);
        check("line11 first addr", 32'(read_addr), 32'h01600);
        run_range(701, 799, 10);

        // Line 11 recovers after the flush; its prefetch event is skipped.
        exp_line = 11;
        run_range(0, 699, 11);
        run_range(701, 799, 11);
        check("underrun before", 32'(underrun), 32'h0);

        // Line 12 has nothing fetched: every active pixel is 0 and underruns.
        exp_valid = 1'b0;
        run_range(0, 699, 12);
        check("underrun empty line", 32'(underrun), 32'h1);
        run_range(700, 799, 12);

        // Line 13 streams; prefetch at vcount=2 targets line 3.
        exp_valid = 1'b1;
        exp_line  = 13;
        run_range(0, 699, 13);
        run_range(700, 799, 2);

        // Line 3 with reset at hcount=320.
        exp_line = 3;
        run_range(0, 319, 3);
        reset  = 1'b1;
        hcount = 11'd320;
        vcount = 10'd3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst read_addr", 32'(read_addr), 32'h0);
        check("midrst pixel", 32'(pixel), 32'h0);
        check("midrst pixel_active", 32'(pixel_active), 32'h0);
        check("midrst underrun", 32'(underrun), 32'h0);
        check("midrst sync_err", 32'(sync_err), 32'h0);
        exp_valid = 1'b0;
        run_range(321, 799, 3);
        check("underrun after reset", 32'(underrun), 32'h1);
        check("sync_err after reset", 32'(sync_err), 32'h0);

        // Line 4 streams; prefetch at vcount=479 targets 480 and idles.
        exp_valid = 1'b1;
        exp_line  = 4;
        run_range(0, 699, 4);
        run_range(700, 799, 479);
        check("idle addr after 479", 32'(read_addr), 32'h0093F);
        run_range(0, 799, 480);
        check("idle addr line 480", 32'(read_addr), 32'h0093F);

        // vcount=524 event restarts at line 0.
        run_range(0, 699, 524);
        cyc(700, 524);
        check("frame restart addr", 32'(read_addr), 32'h00000);
        run_range(701, 799, 524);
        exp_line = 0;
        run_range(0, 799, 0);
        check("underrun sticky", 32'(underrun), 32'h1);
        check("sync_err clean frame", 32'(sync_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/zbt_pix_reader.md
# zbt_pix_reader

Display-side reader for ZBT bank 1: it fetches the packed two-pixel words that the pixel-processing path writes, and streams them out one 18-bit RGB pixel per clock, aligned to hcount/vcount, toward the VGA output. Each line is prefetched during horizontal blanking into a small credit-managed word FIFO. The FIFO absorbs the fixed ZBT read latency, and the block flags underrun and line-sync errors.

## Interface
- H_ACTIVE, 640: active pixels per line (even).
- V_ACTIVE, 480: active lines.
- H_TOTAL, 800: hcount period.
- V_TOTAL, 525: vcount period.
- H_PREFETCH, 700: hcount value that starts next-line prefetch; must satisfy H_ACTIVE ≤ H_PREFETCH < H_TOTAL.
- ZBT_LAT, 2: cycles from read_addr register update to valid read_data.
- DEPTH, 8: word FIFO depth (power of 2, ≥ ZBT_LAT+2).
- Ports:
  - clk  in  1  pixel clock, the only clock.
  - reset  in  1  synchronous, active-high.
  - hcount  in  11  horizontal counter, same timing as the display pipeline.
  - vcount  in  10  vertical counter.
  - read_data  in  36  ZBT bank 1 read word: {pixel even [35:18], pixel odd [17:0]}.
  - read_addr  out  19  ZBT bank 1 read address (registered).
  - pixel  out  18  RGB 6/6/6 for the previous cycle's hcount/vcount.
  - pixel_active  out  1  pixel corresponds to an active-region position.
  - underrun  out  1  sticky; an active pixel found the FIFO empty.
  - sync_err  out  1  sticky; words remained or were in flight at a prefetch event.

## Operation
- Address map: read_addr = {line[9:0], col[8:0]}, where col is the word index (0..H_ACTIVE/2-1).
- Prefetch event: fires in the cycle hcount == H_PREFETCH.
  - Target line: next = (vcount == V_TOTAL-1) ? 0 : vcount+1.
  - If next < V_ACTIVE: fetch line ← next, col ← 0, FSM → FETCH.
  - Otherwise: FSM → IDLE.
- Fetch FSM states:
  - IDLE: no reads issued. Exits only on a prefetch event.
  - FETCH: issue one read per cycle while count + inflight < DEPTH. Each issue registers read_addr and increments col. After issuing col == H_ACTIVE/2-1 → DONE.
  - DONE: no reads issued. Prefetch event → FETCH or IDLE, per the event rule above.
- Return path: a valid bit per issue travels through a ZBT_LAT+1 stage shift pipeline. When the bit exits, read_data is pushed into the FIFO. inflight = number of set bits in the pipeline.
- Credit rule: count + inflight never exceeds DEPTH, so the FIFO never overflows. No overflow flag exists.
- Consumption: active when hcount < H_ACTIVE and vcount < V_ACTIVE.
  - Even hcount: pixel ← head[35:18].
  - Odd hcount: pixel ← head[17:0], then the head word is popped.
  - If the FIFO is empty on an active position: pixel ← 0, underrun ← 1, no pop.
- Inactive positions: pixel ← 0, pixel_active ← 0, no pop.
- Prefetch event with count ≠ 0 or inflight ≠ 0:
  - sync_err ← 1.
  - FIFO flushed (count ← 0).
  - All return-pipeline valid bits cleared.
  - New line fetch starts in the same event.
- Sticky flags clear only on reset.
- Push and pop in the same cycle: count unchanged, head advances.

## Timing
- pixel and pixel_active are registered: values in cycle t+1 correspond to hcount/vcount sampled in cycle t.
- Read latency: an issue decided in cycle t drives read_addr in t+1. Data arrives in t+1+ZBT_LAT and is in the FIFO (poppable) from t+2+ZBT_LAT.
- Throughput:
  - One word issued per cycle; one word consumed per two cycles.
  - A full line is fetched in H_ACTIVE/2 + fetch stalls; stalls occur only from credit limits.
  - With defaults, the first DEPTH words are resident by hcount ≈ H_PREFETCH+DEPTH+ZBT_LAT+2, before line start.
- Reset (synchronous): applies in the cycle it is sampled.
  - FSM → IDLE; FIFO and pipeline cleared; col, line ← 0.
  - read_addr, pixel, pixel_active, underrun, sync_err ← 0.
  - A reset mid-line yields underrun on the remaining active pixels of that line (no fetch until the next prefetch event). Normal operation resumes from the next line.

## Test plan
- Reset, then run from vcount=524, hcount=0:
  - At hcount=700, the first issue shows read_addr=0x00000 in the next cycle.
  - Following issues give addresses 0x00001 … 0x00007; issuing then stalls at 8 credits.
- Model ZBT returning word(addr) = {addr[17:0], ~addr[17:0]} with 2-cycle latency, line 0:
  - pixel sequence 0x00000, 0x3FFFF, 0x00001, 0x3FFFE, …
  - pixel_active high for exactly 640 cycles per line; underrun stays 0 over a full frame.
- Line 5: read_addr for col 319 = {10'd5, 9'd319} = 0x00B3F. FSM enters DONE; no further issues until hcount=700.
- vcount=479 prefetch event (next=480): no reads issued for lines 480–524. The vcount=524 event targets line 0, with addresses restarting at 0x00000.
- Force read_data valid one cycle late (ZBT_LAT mismatch) or block returns on line 10:
  - underrun → 1 and pixel=0 for each active pixel seen with the FIFO empty.
  - At the next prefetch event, residual words set sync_err=1; the following line still streams correctly.
- Assert reset at hcount=320 of line 3:
  - All outputs read 0 in the next cycle.
  - Line 3's remaining pixels output 0 with underrun=1.
  - Line 4 streams correctly from its prefetch at hcount=700 of line 3.
